// File: rtl/rfsoc_config.sv
// Shared GPIO configuration constants: pin map, field enumeration and frame lengths.
package rfsoc_config;

    localparam int config_reg_width = 32;

    localparam int GPIO_SDATA    = 0;
    localparam int GPIO_TRIGGER  = 1;
    localparam int GPIO_CLK_BASE = 2;

    typedef enum logic [3:0] {
        CFG_CHANNEL_SEL      = 4'd0,
        CFG_CYCLE_COUNT      = 4'd1,
        CFG_PRE_DELAY        = 4'd2,
        CFG_POST_DELAY       = 4'd3,
        CFG_ADC_RUN          = 4'd4,
        CFG_ADC_SHIFT        = 4'd5,
        CFG_MASK             = 4'd6,
        CFG_LOCKING_WAVEFORM = 4'd7,
        CFG_MUX_SEL          = 4'd8,
        CFG_MASK_ENABLE      = 4'd9
    } cfg_field_e;

    localparam int NUM_CFG_FIELDS = 10;

    localparam int CHANNEL_SEL_LEN = 16;
    localparam int WORD_LEN        = config_reg_width;
    localparam int WIDE_LEN        = 256;
    localparam int FLAG_LEN        = 8;

    // Each field has its own serial clock line, laid out after sdata and trigger.
    function automatic int clk_bit(cfg_field_e f);
        return GPIO_CLK_BASE + int'(f);
    endfunction

endpackage

// File: rtl/rfsoc_serial_field_rx.sv
// One serial config field: LSB-first shift register, bit counter, commit and strobe.
// Commits on the shift that absorbs bit WIDTH-1; abort drops a partial frame only.
module rfsoc_serial_field_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             sdata,
    input  logic             abort,
    output logic [WIDTH-1:0] data,
    output logic             upd,
    output logic             active
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] next_sreg;
    logic [CW-1:0]    cnt;

    // New bits enter at the top so the first bit received lands at bit 0.
    assign next_sreg = {sdata, sreg[WIDTH-1:1]};
    assign active    = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            data <= '0;
            upd  <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (shift) begin
                sreg <= next_sreg;
                if (cnt == CW'(WIDTH - 1)) begin
                    data <= next_sreg;
                    upd  <= 1'b1;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (abort) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rfsoc_gpio_cfg_rx.sv
// Receives serial configuration words bit-banged by the PS over an asynchronous GPIO bus.
// Commit lands 2 ps_clk cycles after the final field-clock high is first sampled.
module rfsoc_gpio_cfg_rx
    import rfsoc_config::*;
#(
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic                        ps_clk,
    input  logic                        rst,
    input  logic [15:0]                 gpio_ctrl,
    output logic [15:0]                 channel_sel,
    output logic [config_reg_width-1:0] cycle_count,
    output logic [config_reg_width-1:0] pre_delay_cycles,
    output logic [config_reg_width-1:0] post_delay_cycles,
    output logic [config_reg_width-1:0] adc_run_cycles,
    output logic [config_reg_width-1:0] adc_shift_val,
    output logic [255:0]                mask,
    output logic [255:0]                locking_waveform,
    output logic                        mux_sel,
    output logic                        mask_enable,
    output logic [NUM_CFG_FIELDS-1:0]   field_upd,
    output logic                        trigger_pulse,
    output logic                        frame_abort
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    logic [15:0]               sync1, sync2, sync3;
    logic [2:0]                primed;
    logic [NUM_CFG_FIELDS-1:0] fedge;
    logic [NUM_CFG_FIELDS-1:0] factive;
    logic [IW-1:0]             idle_cnt;
    logic                      any_edge;
    logic                      timeout;
    logic                      sdata;
    logic                      trig_rise;
    logic [FLAG_LEN-1:0]       mux_word;
    logic [FLAG_LEN-1:0]       men_word;

    // Edges stay masked until sync3 holds real samples, so a line already high
    // at reset release never looks like a rising edge.
    always_comb begin
        fedge = '0;
        for (int f = 0; f < NUM_CFG_FIELDS; f++) begin
            fedge[f] = primed[2] & sync2[GPIO_CLK_BASE + f] & ~sync3[GPIO_CLK_BASE + f];
        end
    end

    assign trig_rise = primed[2] & sync2[GPIO_TRIGGER] & ~sync3[GPIO_TRIGGER];
    assign sdata     = sync2[GPIO_SDATA];
    assign any_edge  = |fedge;
    assign timeout   = !any_edge && (idle_cnt == IW'(IDLE_TIMEOUT - 1));

    always_ff @(posedge ps_clk) begin
        if (rst) begin
            sync1         <= '0;
            sync2         <= '0;
            sync3         <= '0;
            primed        <= '0;
            idle_cnt      <= '0;
            trigger_pulse <= 1'b0;
            frame_abort   <= 1'b0;
        end else begin
            sync1         <= gpio_ctrl;
            sync2         <= sync1;
            sync3         <= sync2;
            primed        <= {primed[1:0], 1'b1};
            trigger_pulse <= trig_rise;
            frame_abort   <= timeout && (|factive);
            if (any_edge) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IW'(IDLE_TIMEOUT)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    rfsoc_serial_field_rx #(.WIDTH(CHANNEL_SEL_LEN)) u_channel_sel (
        .clk(ps_clk), .rst(rst), .shift(fedge[CFG_CHANNEL_SEL]), .sdata(sdata), .abort(timeout),
        .data(channel_sel), .upd(field_upd[CFG_CHANNEL_SEL]), .active(factive[CFG_CHANNEL_SEL]));

    rfsoc_serial_field_rx #(.WIDTH(WORD_LEN)) u_cycle_count (
        .clk(ps_clk), .rst(rst), .shift(fedge[CFG_CYCLE_COUNT]), .sdata(sdata), .abort(timeout),
        .data(cycle_count), .upd(field_upd[CFG_CYCLE_COUNT]), .active(factive[CFG_CYCLE_COUNT]));

    rfsoc_serial_field_rx #(.WIDTH(WORD_LEN)) u_pre_delay (
        .clk(ps_clk), .rst(rst), .shift(fedge[CFG_PRE_DELAY]), .sdata(sdata), .abort(timeout),
        .data(pre_delay_cycles), .upd(field_upd[CFG_PRE_DELAY]), .active(factive[CFG_PRE_DELAY]));

    rfsoc_serial_field_rx #(.WIDTH(WORD_LEN)) u_post_delay (
        .clk(ps_clk), .rst(rst), .shift(fedge[CFG_POST_DELAY]), .sdata(sdata), .abort(timeout),
        .data(post_delay_cycles), .upd(field_upd[CFG_POST_DELAY]), .active(factive[CFG_POST_DELAY]));

    rfsoc_serial_field_rx #(.WIDTH(WORD_LEN)) u_adc_run (
        .clk(ps_clk), .rst(rst), .shift(fedge[CFG_ADC_RUN]), .sdata(sdata), .abort(timeout),
        .data(adc_run_cycles), .upd(field_upd[CFG_ADC_RUN]), .active(factive[CFG_ADC_RUN]));

    rfsoc_serial_field_rx #(.WIDTH(WORD_LEN)) u_adc_shift (
        .clk(ps_clk), .rst(rst), .shift(fedge[CFG_ADC_SHIFT]), .sdata(sdata), .abort(timeout),
        .data(adc_shift_val), .upd(field_upd[CFG_ADC_SHIFT]), .active(factive[CFG_ADC_SHIFT]));

    rfsoc_serial_field_rx #(.WIDTH(WIDE_LEN)) u_mask (
        .clk(ps_clk), .rst(rst), .shift(fedge[CFG_MASK]), .sdata(sdata), .abort(timeout),
        .data(mask), .upd(field_upd[CFG_MASK]), .active(factive[CFG_MASK]));

    rfsoc_serial_field_rx #(.WIDTH(WIDE_LEN)) u_locking (
        .clk(ps_clk), .rst(rst), .shift(fedge[CFG_LOCKING_WAVEFORM]), .sdata(sdata), .abort(timeout),
        .data(locking_waveform), .upd(field_upd[CFG_LOCKING_WAVEFORM]),
        .active(factive[CFG_LOCKING_WAVEFORM]));

    rfsoc_serial_field_rx #(.WIDTH(FLAG_LEN)) u_mux_sel (
        .clk(ps_clk), .rst(rst), .shift(fedge[CFG_MUX_SEL]), .sdata(sdata), .abort(timeout),
        .data(mux_word), .upd(field_upd[CFG_MUX_SEL]), .active(factive[CFG_MUX_SEL]));

    rfsoc_serial_field_rx #(.WIDTH(FLAG_LEN)) u_mask_enable (
        .clk(ps_clk), .rst(rst), .shift(fedge[CFG_MASK_ENABLE]), .sdata(sdata), .abort(timeout),
        .data(men_word), .upd(field_upd[CFG_MASK_ENABLE]), .active(factive[CFG_MASK_ENABLE]));

    // Flag frames are a byte wide but only the last bit sent carries the flag.
    assign mux_sel     = mux_word[FLAG_LEN-1];
    assign mask_enable = men_word[FLAG_LEN-1];

endmodule

// File: tb/tb_rfsoc_gpio_cfg_rx.sv
// Directed bench for rfsoc_gpio_cfg_rx: bit-bangs frames over gpio_ctrl and checks commits.
module tb_rfsoc_gpio_cfg_rx;
    import rfsoc_config::*;

    localparam int IDLE = 64;

    logic                        ps_clk = 1'b0;
    logic                        rst;
    logic [15:0]                 gpio_ctrl;
    logic [15:0]                 channel_sel;
    logic [config_reg_width-1:0] cycle_count, pre_delay_cycles, post_delay_cycles;
    logic [config_reg_width-1:0] adc_run_cycles, adc_shift_val;
    logic [255:0]                mask, locking_waveform;
    logic                        mux_sel, mask_enable;
    logic [NUM_CFG_FIELDS-1:0]   field_upd;
    logic                        trigger_pulse, frame_abort;

    int checks   = 0;
    int failures = 0;
    int upd_cnt [NUM_CFG_FIELDS];
    int trig_cnt  = 0;
    int abort_cnt = 0;

    rfsoc_gpio_cfg_rx #(.IDLE_TIMEOUT(IDLE)) dut (
        .ps_clk(ps_clk), .rst(rst), .gpio_ctrl(gpio_ctrl),
        .channel_sel(channel_sel), .cycle_count(cycle_count),
        .pre_delay_cycles(pre_delay_cycles), .post_delay_cycles(post_delay_cycles),
        .adc_run_cycles(adc_run_cycles), .adc_shift_val(adc_shift_val),
        .mask(mask), .locking_waveform(locking_waveform),
        .mux_sel(mux_sel), .mask_enable(mask_enable), .field_upd(field_upd),
        .trigger_pulse(trigger_pulse), .frame_abort(frame_abort));

    always #5 ps_clk = ~ps_clk;

    initial for (int i = 0; i < NUM_CFG_FIELDS; i++) upd_cnt[i] = 0;

    always @(posedge ps_clk) begin
        for (int i = 0; i < NUM_CFG_FIELDS; i++)
            if (field_upd[i]) upd_cnt[i] <= upd_cnt[i] + 1;
        if (trigger_pulse) trig_cnt  <= trig_cnt + 1;
        if (frame_abort)   abort_cnt <= abort_cnt + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cm(input cfg_field_e f);
        logic [15:0] m;
        m = '0;
        m[clk_bit(f)] = 1'b1;
        return m;
    endfunction

    // Leaves the clock line(s) high on return, at a falling ps_clk edge.
    task automatic send_bit(input logic [15:0] clks, input logic b);
        @(negedge ps_clk);
        gpio_ctrl[GPIO_SDATA] = b;
        gpio_ctrl = gpio_ctrl & ~clks;
        repeat (2) @(negedge ps_clk);
        gpio_ctrl = gpio_ctrl | clks;
    endtask

    task automatic send_frame(input logic [15:0] clks, input logic [255:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(clks, v[i]);
            repeat (2) @(negedge ps_clk);
        end
        repeat (4) @(negedge ps_clk);
        gpio_ctrl = gpio_ctrl & ~clks;
    endtask

    initial begin
        logic [255:0] v;
        int a0;

        // Reset with trigger and a field clock already high.
        rst = 1'b1;
        gpio_ctrl = '0;
        gpio_ctrl[GPIO_TRIGGER] = 1'b1;
        gpio_ctrl = gpio_ctrl | cm(CFG_CHANNEL_SEL);
        repeat (3) @(negedge ps_clk);
        chk("rst_channel_sel", channel_sel, 16'h0000);
        chk("rst_field_upd", field_upd, '0);
        chk("rst_cycle_count", cycle_count, '0);
        chk("rst_frame_abort", frame_abort, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge ps_clk);
        chk("no_trig_at_release", trig_cnt, 0);
        gpio_ctrl = '0;

        send_frame(cm(CFG_CHANNEL_SEL), 256'h0020, CHANNEL_SEL_LEN);
        chk("channel_sel", channel_sel, 16'h0020);
        chk("channel_sel_strobes", upd_cnt[CFG_CHANNEL_SEL], 1);

        // cycle_count = 10, final bit sent by hand to observe commit latency.
        v = 256'd10;
        send_frame(cm(CFG_CYCLE_COUNT), v, WORD_LEN - 1);
        send_bit(cm(CFG_CYCLE_COUNT), v[WORD_LEN-1]);
        @(negedge ps_clk);
        @(negedge ps_clk);
        chk("cycle_count_early", cycle_count, '0);
        @(negedge ps_clk);
        chk("cycle_count", cycle_count, 32'd10);
        chk("cycle_upd_high", field_upd[CFG_CYCLE_COUNT], 1'b1);
        @(negedge ps_clk);
        chk("cycle_upd_low", field_upd[CFG_CYCLE_COUNT], 1'b0);
        gpio_ctrl = '0;
        repeat (4) @(negedge ps_clk);
        chk("cycle_strobes", upd_cnt[CFG_CYCLE_COUNT], 1);

        v = {{8{16'h0000}}, {8{16'hFFFF}}};
        send_frame(cm(CFG_MASK), v, WIDE_LEN);
        chk("mask", mask, v);
        chk("mask_strobes", upd_cnt[CFG_MASK], 1);

        send_frame(cm(CFG_MUX_SEL), 256'hFF, FLAG_LEN);
        chk("mux_sel", mux_sel, 1'b1);
        send_frame(cm(CFG_MASK_ENABLE), 256'h7F, FLAG_LEN);
        chk("mask_enable_bit7_low", mask_enable, 1'b0);
        send_frame(cm(CFG_MASK_ENABLE), 256'h80, FLAG_LEN);
        chk("mask_enable_bit7_high", mask_enable, 1'b1);

        // Two fields clocked together receive the same bits.
        send_frame(cm(CFG_POST_DELAY) | cm(CFG_ADC_RUN), 256'h12345678, WORD_LEN);
        chk("post_delay_shared", post_delay_cycles, 32'h12345678);
        chk("adc_run_shared", adc_run_cycles, 32'h12345678);
        chk("adc_shift_untouched", adc_shift_val, '0);

        // Partial frame followed by idle timeout.
        send_frame(cm(CFG_PRE_DELAY), 256'd9, WORD_LEN);
        send_frame(cm(CFG_PRE_DELAY), 256'd5, 7);
        repeat (IDLE + 10) @(negedge ps_clk);
        chk("abort_count", abort_cnt, 1);
        chk("pre_delay_kept", pre_delay_cycles, 32'd9);
        repeat (IDLE + 10) @(negedge ps_clk);
        chk("abort_once", abort_cnt, 1);
        send_frame(cm(CFG_PRE_DELAY), 256'd2, WORD_LEN);
        chk("pre_delay_after_abort", pre_delay_cycles, 32'd2);
        chk("pre_delay_strobes", upd_cnt[CFG_PRE_DELAY], 2);

        // Trigger edges.
        @(negedge ps_clk);
        gpio_ctrl[GPIO_TRIGGER] = 1'b1;
        repeat (5) @(negedge ps_clk);
        gpio_ctrl[GPIO_TRIGGER] = 1'b0;
        repeat (5) @(negedge ps_clk);
        chk("trigger_held", trig_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            gpio_ctrl[GPIO_TRIGGER] = 1'b1;
            repeat (2) @(negedge ps_clk);
            gpio_ctrl[GPIO_TRIGGER] = 1'b0;
            repeat (4) @(negedge ps_clk);
        end
        repeat (4) @(negedge ps_clk);
        chk("trigger_four", trig_cnt, 5);

        // Reset in the middle of a locking_waveform frame.
        a0 = abort_cnt;
        send_frame(cm(CFG_LOCKING_WAVEFORM), {16{16'hABCD}}, 100);
        rst = 1'b1;
        repeat (2) @(negedge ps_clk);
        rst = 1'b0;
        repeat (IDLE + 10) @(negedge ps_clk);
        chk("lock_no_strobe", upd_cnt[CFG_LOCKING_WAVEFORM], 0);
        chk("lock_no_abort", abort_cnt, a0);
        chk("lock_cleared", locking_waveform, '0);
        chk("cycle_count_cleared", cycle_count, '0);
        send_frame(cm(CFG_LOCKING_WAVEFORM), {16{16'h1111}}, WIDE_LEN);
        chk("locking_waveform", locking_waveform, {16{16'h1111}});
        chk("lock_strobes", upd_cnt[CFG_LOCKING_WAVEFORM], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rfsoc_gpio_cfg_rx.md
RFSOC_GPIO_CFG_RX -- requirements
Module: rfsoc_gpio_cfg_rx

Interface
REQ-001 SHALL have parameter IDLE_TIMEOUT, default 4096, ps_clk cycles without any serial-clock edge before partial frames are discarded.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have ports:
- ps_clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- gpio_ctrl  in  16  asynchronous GPIO bus from PS; bit positions from rfsoc_config (sdata, trigger_line, *_clk).
- channel_sel  out  16  one-hot selected channel.
- cycle_count, pre_delay_cycles, post_delay_cycles, adc_run_cycles, adc_shift_val  out  config_reg_width each  committed words.
- mask, locking_waveform  out  256 each  committed words.
- mux_sel, mask_enable  out  1 each  committed flags.
- field_upd  out  NUM_CFG_FIELDS  one-cycle commit strobe per field, indexed by package enum.
- trigger_pulse  out  1  one-cycle pulse per trigger rising edge.
- frame_abort  out  1  one-cycle pulse when a timeout discards any partial frame.

Function
REQ-004 SHALL pass all 16 gpio_ctrl bits through a two-flop synchronizer, then a third register for edge detection; sdata and field clocks share this path so their alignment is preserved.
REQ-005 SHALL, on a synchronized rising edge of a field clock, shift the synchronized sdata into that field's shift register, LSB first: first bit received ends at bit 0.
REQ-006 SHALL use frame lengths: channel_sel 16; cycle_count, pre/post delay, adc run cycles, adc shift val config_reg_width; mask and locking_waveform 256; mux_sel and mask_enable 8.
REQ-007 SHALL keep a per-field bit counter; on the edge absorbing the final bit, it SHALL copy the shift register to the output, pulse that field's field_upd for one cycle and clear the counter.
REQ-008 SHALL take mux_sel and mask_enable from bit 7 of their 8-bit shift register at commit.
REQ-009 SHALL hold outputs unchanged between commits; partial frames SHALL never be visible.
REQ-010 SHALL commit outputs and strobes 2 ps_clk cycles after the first rising ps_clk edge that samples the final field-clock high.
REQ-011 SHALL shift the same sdata bit into every field whose clock edges in the same cycle; fields SHALL be independent, and an edge on one field SHALL NOT abort another.
REQ-012 SHALL run an idle counter that clears on any field-clock edge; at IDLE_TIMEOUT it SHALL clear every nonzero bit counter and pulse frame_abort once; committed outputs SHALL be unchanged.
REQ-013 SHALL generate trigger_pulse on a synchronized trigger_line rising edge only; a held-high level SHALL give exactly one pulse.
REQ-014 SHALL detect only field-clock rising edges; a field clock held high SHALL shift exactly one bit.

Reset
REQ-015 SHALL, while rst is high at a ps_clk edge, clear synchronizers, shift registers, bit counters, idle counter and all outputs to 0, including channel_sel = 16'h0000 and field_upd = 0.
REQ-016 SHALL discard an in-flight frame when reset is asserted mid-frame, with no field_upd and no frame_abort pulse.
REQ-017 SHALL NOT produce any trigger_pulse or field-clock edge from a gpio line already high at reset release; edge history SHALL restart from the reset value 0.

Structure
REQ-018 SHALL take GPIO bit indices, config_reg_width, field-enum and NUM_CFG_FIELDS from shared package rfsoc_config; frame lengths SHALL be package constants.
REQ-019 SHALL use one sub-module, rfsoc_serial_field_rx (parameter WIDTH), instantiated once per field, holding shift register, bit counter, commit and strobe logic.

Verification
REQ-020 SHALL verify: shift cycle_count = 10 LSB first (config_reg_width bits) -> cycle_count == 10, field_upd[CYCLE_COUNT] high exactly one cycle.
REQ-021 SHALL verify: mask = {8{16'h0000},8{16'hFFFF}} -> mask[127:0] all ones, mask[255:128] zero, one strobe.
REQ-022 SHALL verify: channel select frame with bit 5 only set -> channel_sel == 16'h0020; mux_sel frame of eight 1s -> mux_sel == 1.
REQ-023 SHALL verify: 7 bits of pre_delay, then IDLE_TIMEOUT+2 idle cycles -> one frame_abort, pre_delay_cycles unchanged; a following full frame of value 2 -> pre_delay_cycles == 2.
REQ-024 SHALL verify: trigger_line high for 5 cycles -> exactly one trigger_pulse; 4 separated triggers -> 4 pulses.
REQ-025 SHALL verify: rst asserted after 100 of 256 locking_waveform bits -> no strobe; a following full frame of {16{16'h1111}} commits exactly.
